// File: rtl/rtc_timebase_if.sv
// rtc_timebase_if -- control/status bundle for the centisecond timebase.
//   i_count_init  : synchronous clear request (trigger control -> timebase)
//   i_count_enb   : run enable               (trigger control -> timebase)
//   i_latch_count : display-follow enable    (trigger control -> timebase)
//   o_tick        : one-cycle pulse per 10 ms (timebase -> consumers)
//   o_count       : live centisecond count
//   o_display     : latched count for the display path
//   o_overflow    : sticky wrap flag
// slave modport is the timebase side, master is the controller side.
interface rtc_timebase_if #(
    parameter int CNT_W = 24
);
    logic             i_count_init;
    logic             i_count_enb;
    logic             i_latch_count;
    logic             o_tick;
    logic [CNT_W-1:0] o_count;
    logic [CNT_W-1:0] o_display;
    logic             o_overflow;

    modport slave (
        input  i_count_init, i_count_enb, i_latch_count,
        output o_tick, o_count, o_display, o_overflow
    );

    modport master (
        output i_count_init, i_count_enb, i_latch_count,
        input  o_tick, o_count, o_display, o_overflow
    );
endinterface

// File: rtl/rtc_timebase.sv
// rtc_timebase -- 10 ms tick generator with centisecond elapsed counter,
// lap/freeze display latch and sticky overflow.
//   i_sclk    : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : rtc_timebase_if.slave (controls in, tick/count/display/overflow out)
// Controls are assumed synchronous to i_sclk. Every output comes straight
// from a flop.
module rtc_timebase #(
    parameter int DIV_BOUND = 1000000,
    parameter int CNT_W     = 24
) (
    input  logic          i_sclk,
    input  logic          i_reset_n,
    rtc_timebase_if.slave bus
);
    localparam int PRE_W = (DIV_BOUND > 1) ? $clog2(DIV_BOUND) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_BOUND - 1);

    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] disp_q;
    logic             tick_q;
    logic             ovf_q;
    logic             term;

    // Terminal count only while running; a paused prescaler keeps its
    // partial interval.
    assign term = bus.i_count_enb && (pre_q == PRE_LAST);

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.i_count_init) begin
            // Clear wins over enable, latch and a coincident terminal count.
            pre_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tick_q <= term;
            if (bus.i_count_enb)
                pre_q <= term ? '0 : pre_q + 1'b1;
            if (term) begin
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q)
                    ovf_q <= 1'b1;
            end
            // Samples the pre-edge count: one cycle lag, and a coincident
            // tick shows the pre-increment value.
            if (bus.i_latch_count)
                disp_q <= cnt_q;
        end
    end

    assign bus.o_tick     = tick_q;
    assign bus.o_count    = cnt_q;
    assign bus.o_display  = disp_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_rtc_timebase.sv
// tb_rtc_timebase -- directed bench for rtc_timebase. Two instances with
// DIV_BOUND=4 (CNT_W=24 and CNT_W=4) share the same control inputs. A model
// derives outputs from the number of enabled edges since the last clear,
// and is compared on every falling edge; literal checks pin the scenarios.
module tb_rtc_timebase;
    localparam int DIV = 4;

    logic sclk = 1'b0;
    logic rst_n;
    logic init, enb, latch;
    int   errs = 0;
    int   checks = 0;

    always #5 sclk = ~sclk;

    rtc_timebase_if #(.CNT_W(24)) bus_a ();
    rtc_timebase_if #(.CNT_W(4))  bus_w ();

    assign bus_a.i_count_init  = init;
    assign bus_a.i_count_enb   = enb;
    assign bus_a.i_latch_count = latch;
    assign bus_w.i_count_init  = init;
    assign bus_w.i_count_enb   = enb;
    assign bus_w.i_latch_count = latch;

    rtc_timebase #(.DIV_BOUND(DIV), .CNT_W(24)) dut_a (
        .i_sclk(sclk), .i_reset_n(rst_n), .bus(bus_a.slave));
    rtc_timebase #(.DIV_BOUND(DIV), .CNT_W(4))  dut_w (
        .i_sclk(sclk), .i_reset_n(rst_n), .bus(bus_w.slave));

    // Model: n = enabled edges since clear; count = (n/DIV) mod 2^W.
    longint n;
    logic   m_tick;
    longint m_disp_a, m_disp_w;

    function automatic longint cnt_of(longint nn, int w);
        return (nn / DIV) % (longint'(1) << w);
    endfunction

    function automatic longint ovf_of(longint nn, int w);
        return ((nn / DIV) >= (longint'(1) << w)) ? 1 : 0;
    endfunction

    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_tick = 0; m_disp_a = 0; m_disp_w = 0;
        end else if (init) begin
            n = 0; m_tick = 0; m_disp_a = 0; m_disp_w = 0;
        end else begin
            if (latch) begin
                m_disp_a = cnt_of(n, 24);
                m_disp_w = cnt_of(n, 4);
            end
            if (enb) n = n + 1;
            m_tick = enb && (n % DIV == 0);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sclk) begin
        chk("a.tick",  longint'(bus_a.o_tick),     longint'(m_tick));
        chk("a.count", longint'(bus_a.o_count),    cnt_of(n, 24));
        chk("a.disp",  longint'(bus_a.o_display),  m_disp_a);
        chk("a.ovf",   longint'(bus_a.o_overflow), ovf_of(n, 24));
        chk("w.tick",  longint'(bus_w.o_tick),     longint'(m_tick));
        chk("w.count", longint'(bus_w.o_count),    cnt_of(n, 4));
        chk("w.disp",  longint'(bus_w.o_display),  m_disp_w);
        chk("w.ovf",   longint'(bus_w.o_overflow), ovf_of(n, 4));
    end

    // Set controls at a falling edge and advance across one rising edge.
    task automatic step(input logic i_in, input logic i_en, input logic i_la);
        init = i_in; enb = i_en; latch = i_la;
        @(negedge sclk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".count"}, longint'(bus_a.o_count),    0);
        chk({tag, ".disp"},  longint'(bus_a.o_display),  0);
        chk({tag, ".tick"},  longint'(bus_a.o_tick),     0);
        chk({tag, ".ovf"},   longint'(bus_a.o_overflow), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] tmask;
        rst_n = 1'b0; init = 1'b0; enb = 1'b0; latch = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        chk_zero("reset");
        rst_n = 1'b1;
        step(1, 0, 0);

        // Basic count and display
        tmask = '0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1);
            tmask[i] = bus_a.o_tick;
        end
        chk("basic.tickmask", longint'(tmask), 64'h888);
        chk("basic.count", longint'(bus_a.o_count), 3);
        chk("basic.disp_lag", longint'(bus_a.o_display), 2);
        step(0, 0, 1);
        chk("basic.disp", longint'(bus_a.o_display), 3);

        // Pause and resume
        step(1, 0, 0);
        repeat (6) step(0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            chk("pause.count", longint'(bus_a.o_count), 1);
        end
        step(0, 1, 0);
        chk("resume1.tick", longint'(bus_a.o_tick), 0);
        chk("resume1.count", longint'(bus_a.o_count), 1);
        step(0, 1, 0);
        chk("resume2.tick", longint'(bus_a.o_tick), 1);
        chk("resume2.count", longint'(bus_a.o_count), 2);

        // Lap freeze
        step(1, 0, 0);
        for (int i = 0; i < 20 && bus_a.o_count != 24'd2; i++) step(0, 1, 1);
        chk("lap.reach", longint'(bus_a.o_count), 2);
        step(0, 1, 1);
        chk("lap.disp_set", longint'(bus_a.o_display), 2);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            chk("lap.frozen", longint'(bus_a.o_display), 2);
        end
        chk("lap.count", longint'(bus_a.o_count), 4);
        step(0, 0, 1);
        chk("lap.restore", longint'(bus_a.o_display), 4);

        // Wrap on the 4-bit instance
        step(1, 0, 0);
        repeat (60) step(0, 1, 1);
        chk("wrap.pre_count", longint'(bus_w.o_count), 15);
        chk("wrap.pre_ovf", longint'(bus_w.o_overflow), 0);
        repeat (4) step(0, 1, 1);
        chk("wrap.count", longint'(bus_w.o_count), 0);
        chk("wrap.ovf", longint'(bus_w.o_overflow), 1);
        chk("wrap.a_count", longint'(bus_a.o_count), 16);
        repeat (12) step(0, 1, 1);
        chk("wrap.after3_count", longint'(bus_w.o_count), 3);
        chk("wrap.after3_ovf", longint'(bus_w.o_overflow), 1);
        step(1, 0, 0);
        chk("wrap.init_ovf", longint'(bus_w.o_overflow), 0);

        // Init coinciding with terminal count
        repeat (3) step(0, 1, 1);
        step(1, 1, 1);
        chk_zero("initprio");
        step(0, 0, 0);
        chk("initprio.tick_after", longint'(bus_a.o_tick), 0);

        // Async reset mid-interval (count 5, prescaler 2)
        step(1, 0, 0);
        repeat (22) step(0, 1, 1);
        chk("async.pre_count", longint'(bus_a.o_count), 5);
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        @(negedge sclk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            chk("async.no_tick", longint'(bus_a.o_tick), 0);
        end
        step(0, 1, 0);
        chk("async.tick", longint'(bus_a.o_tick), 1);
        chk("async.count", longint'(bus_a.o_count), 1);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rtc_timebase.md
RTC_TIMEBASE -- requirements
Module: rtc_timebase

Interface
REQ-001 Parameter DIV_BOUND, default 1000000, SHALL set the i_sclk cycles per 10 ms tick (legal range >= 2).
REQ-002 Parameter CNT_W, default 24, SHALL set the elapsed-time counter width in centiseconds.
REQ-003 i_sclk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_count_init  input  1  SHALL be the synchronous clear request from the trigger control stage.
REQ-006 i_count_enb  input  1  SHALL be the run enable from the trigger control stage.
REQ-007 i_latch_count  input  1  SHALL be the display-follow enable (1 = display tracks the live count, 0 = display frozen).
REQ-008 o_tick  output  1  SHALL be a one-cycle pulse per elapsed 10 ms.
REQ-009 o_count  output  CNT_W  SHALL be the live elapsed centisecond count.
REQ-010 o_display  output  CNT_W  SHALL be the latched count for the display path.
REQ-011 o_overflow  output  1  SHALL be a sticky flag indicating the count has wrapped.

Function
REQ-012 The prescaler SHALL be ceil(log2(DIV_BOUND)) bits wide and SHALL count 0..DIV_BOUND-1.
REQ-013 The prescaler SHALL increment on each edge with i_count_enb=1 and i_count_init=0.
REQ-014 The prescaler SHALL hold its value when i_count_enb=0, so pause/resume loses no partial interval.
REQ-015 Terminal count SHALL be prescaler==DIV_BOUND-1 with enable active; on that edge the prescaler SHALL return to 0, o_count SHALL increment by 1, and o_tick SHALL be registered high for exactly the following cycle.
REQ-016 From prescaler=0 with enable held, o_tick and the new o_count SHALL first appear after DIV_BOUND rising edges, then every DIV_BOUND edges.
REQ-017 o_count SHALL hold whenever no terminal count occurs.
REQ-018 At o_count = 2^CNT_W-1, a terminal count SHALL wrap o_count to 0 and set o_overflow.
REQ-019 o_overflow SHALL clear only on i_count_init or reset.
REQ-020 With i_latch_count=1, o_display SHALL load the current (pre-edge) o_count every edge, giving one cycle of lag.
REQ-021 With i_latch_count=0, o_display SHALL hold its value while counting continues (lap/freeze).
REQ-022 Effect of i_count_init=1 on the next edge:
  - prescaler, o_count, o_display, o_overflow and o_tick SHALL clear to 0;
  - this SHALL take priority over i_count_enb, i_latch_count and any simultaneous terminal count.
REQ-023 A terminal count coinciding with i_latch_count=1 SHALL give o_display the pre-increment value and o_count the incremented value.
REQ-024 Control inputs SHALL be treated as synchronous to i_sclk; the block SHALL contain no input synchronizers.
REQ-025 All outputs SHALL be driven directly from registers.

Reset
REQ-026 While i_reset_n=0, the prescaler, o_count, o_display, o_overflow and o_tick SHALL be 0 immediately, independent of i_sclk.
REQ-027 After i_reset_n deasserts, operation SHALL resume on the first rising edge, with the prescaler starting from 0.
REQ-028 Reset asserted mid-interval SHALL discard the partial interval, and no o_tick SHALL be produced for it.

Verification (DIV_BOUND=4, CNT_W=24 unless stated)
REQ-029 Basic count and display:
  - stimulus: reset, then init=1 for 1 cycle, then enb=1 and latch=1 for 12 cycles;
  - required: o_tick pulses at cycles 4, 8 and 12 after enb rises; o_count=3; o_display=3 one cycle later.
REQ-030 Pause and resume:
  - stimulus: enb=1 for 6 cycles, enb=0 for 10 cycles, enb=1 for 2 cycles;
  - required: o_count=1 during the pause, then o_count=2 with o_tick at the 2nd cycle after resume.
REQ-031 Lap freeze:
  - stimulus: latch=1 until o_count=2, then latch=0 with enb=1 for 8 cycles;
  - required: o_display stays 2 while o_count reaches 4; on restoring latch=1, o_display=4 after 1 cycle.
REQ-032 Wrap:
  - stimulus: CNT_W=4, run 16 ticks;
  - required: o_count goes 15 -> 0 and o_overflow=1; it stays 1 through 3 more ticks and clears only on init=1.
REQ-033 Init priority:
  - stimulus: init=1 on the same edge as a terminal count, with enb=1 and latch=1;
  - required: on the next edge all outputs are 0 and o_tick stays 0.
REQ-034 Async reset:
  - stimulus: assert i_reset_n=0 between clock edges with o_count=5 and prescaler=2;
  - required: outputs are 0 before the next edge; after release, the first tick comes DIV_BOUND enabled edges later.
